seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning the clk cycles each digit is displayed (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port data  input  32  value to display, 8 hex nibbles; data[3:0] is the rightmost digit.
REQ-005 SHALL have port load  input  1  capture strobe for data, sampled every clk edge.
REQ-006 SHALL have port blank_lz  input  1  leading-zero blanking enable, sampled live every cycle.
REQ-007 SHALL have port anode  output  8  digit enables, active-low; bit i selects digit i.
REQ-008 SHALL have port segment  output  8  segment drives, active-low, order {dp,g,f,e,d,c,b,a}.
REQ-009 SHALL have port frame  output  1  one-cycle pulse when a full 8-digit scan completes.

Function
REQ-010 SHALL run a divider counter div_cnt from 0 to REFRESH_DIV-1, then wrap to 0; tick is asserted when div_cnt == REFRESH_DIV-1.
REQ-011 SHALL advance the 3-bit digit index dig on tick, 0,1,...,7, wrapping 7->0; dig SHALL hold at all other times.
REQ-012 SHALL define frame boundary as tick while dig == 7; frame SHALL be registered high for exactly the cycle after the boundary.
REQ-013 SHALL capture data into pending and set pending_valid on load; a later load before the boundary overwrites pending (last load wins).
REQ-014 SHALL, at a frame boundary with pending_valid = 1, copy pending into the display register disp and clear pending_valid.
REQ-015 SHALL, when load coincides with a frame boundary, load disp directly from data and leave pending_valid = 0.
REQ-016 SHALL change disp only at frame boundaries, so no tearing occurs mid-scan.
REQ-017 SHALL register anode and segment; each cycle they reflect the dig and disp values of the previous cycle (1-cycle latency).
REQ-018 SHALL drive anode = ~(1 << dig) for the shown digit, with all other bits 1.
REQ-019 SHALL decode the nibble disp[4*dig+3:4*dig] with dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E (hex).
REQ-020 SHALL, when blank_lz = 1, blank every digit above the most significant nonzero nibble of disp by driving anode = FF and segment = FF.
REQ-021 SHALL never blank digit 0, so that disp = 0 shows a single "0".
REQ-022 SHALL make no unknown values visible on any output after the first reset.

Reset
REQ-023 SHALL, while rst_n = 0 at a clk edge, set div_cnt=0, dig=0, disp=0, pending=0, pending_valid=0, frame=0, anode=FF, segment=FF.
REQ-024 SHALL, on the first edge after rst_n rises, drive anode=FE and segment=C0.
REQ-025 SHALL discard a pending load when reset is asserted mid-frame, so that disp stays 0 after reset.
REQ-026 SHALL have reset take priority over load and tick in the same cycle.

Verification (REFRESH_DIV=4 in simulation)
REQ-027 SHALL cover: reset release, no load -> anode FE, segment C0 for 4 cycles, then anode FD; frame pulses every 32 cycles.
REQ-028 SHALL cover: load data=12345678 at cycle 5 -> disp unchanged until the first boundary; next frame digit0 shows 80 ("8"), digit7 shows F9 ("1").
REQ-029 SHALL cover: loads of AAAAAAAA then 0000BEEF in the same frame -> next frame shows only BEEF; digit3 segment 83 ("b").
REQ-030 SHALL cover: load coinciding with the boundary cycle (dig=7, div_cnt=3), data=FFFFFFFF -> every digit of the following frame shows 8E.
REQ-031 SHALL cover: blank_lz=1 with disp=00000A05 -> digits 3..7 give anode FF and segment FF, digit2 shows 88, digit1 shows C0, digit0 shows 92; with disp=0, only digit0 shows C0.
REQ-032 SHALL cover: rst_n low for 1 cycle mid-frame after a pending load -> outputs FF/FF that cycle, then FE/C0, and disp stays 0 at the next boundary.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment scanner with frame-synchronous display update.
// Outputs are registered and active-low; disp only changes at the end of a full scan.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  anode,
  output logic [7:0]  segment,
  output logic        frame
);

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic [15:0] r_div_cnt;
  logic [2:0]  r_dig;
  logic [31:0] r_disp;
  logic [31:0] r_pend;
  logic        r_pend_valid;
  logic        r_frame;
  logic [7:0]  r_anode;
  logic [7:0]  r_segment;

  logic        w_tick;
  logic        w_boundary;
  logic [3:0]  w_nibble;
  logic [2:0]  w_msd;
  logic        w_blank;
  logic [7:0]  w_seg;

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_boundary = w_tick && (r_dig == 3'd7);
  assign w_nibble   = r_disp[{r_dig, 2'b00} +: 4];

  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 is never blanked.
  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_disp[4*i +: 4] != 4'h0) w_msd = 3'(i);
    end
  end

  assign w_blank = blank_lz && (r_dig > w_msd);

  always_comb begin
    w_seg = 8'hFF;
    case (w_nibble)
      4'h0: w_seg = 8'hC0;
      4'h1: w_seg = 8'hF9;
      4'h2: w_seg = 8'hA4;
      4'h3: w_seg = 8'hB0;
      4'h4: w_seg = 8'h99;
      4'h5: w_seg = 8'h92;
      4'h6: w_seg = 8'h82;
      4'h7: w_seg = 8'hF8;
      4'h8: w_seg = 8'h80;
      4'h9: w_seg = 8'h90;
      4'hA: w_seg = 8'h88;
      4'hB: w_seg = 8'h83;
      4'hC: w_seg = 8'hC6;
      4'hD: w_seg = 8'hA1;
      4'hE: w_seg = 8'h86;
      4'hF: w_seg = 8'h8E;
      default: w_seg = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_dig        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_frame      <= 1'b0;
      r_anode      <= 8'hFF;
      r_segment    <= 8'hFF;
    end else begin
      r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
      if (w_tick) r_dig <= r_dig + 3'd1;
      r_frame <= w_boundary;

      // A load landing on the boundary bypasses pending so it shows in the very next frame.
      if (load && w_boundary) begin
        r_disp       <= data;
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend       <= data;
        r_pend_valid <= 1'b1;
      end else if (w_boundary && r_pend_valid) begin
        r_disp       <= r_pend;
        r_pend_valid <= 1'b0;
      end

      r_anode   <= w_blank ? 8'hFF : ~(8'b1 << r_dig);
      r_segment <= w_blank ? 8'hFF : w_seg;
    end
  end

  assign anode   = r_anode;
  assign segment = r_segment;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=4.
// A cycle-count based reference model predicts every registered output.
module tb_seg7_scan_driver;

  localparam int DIV = 4;
  localparam int FRAME_LEN = 8 * DIV;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        load;
  logic        blank_lz;
  logic [7:0]  anode;
  logic [7:0]  segment;
  logic        frame;

  int n_err = 0;
  int n_chk = 0;

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: edges since reset, shown value, pending value.
  int          m_n;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  logic        m_pv;
  logic [7:0]  exp_anode;
  logic [7:0]  exp_seg;
  logic        exp_frame;

  seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .load     (load),
    .blank_lz (blank_lz),
    .anode    (anode),
    .segment  (segment),
    .frame    (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_step(input logic r, input logic ld, input logic [31:0] d, input logic blz);
    int  dig;
    int  msd;
    bit  bnd;
    if (!r) begin
      m_n = 0; m_disp = 0; m_pend = 0; m_pv = 0;
      exp_anode = 8'hFF; exp_seg = 8'hFF; exp_frame = 1'b0;
      return;
    end
    dig = (m_n / DIV) % 8;
    bnd = ((m_n % FRAME_LEN) == FRAME_LEN - 1);
    msd = 0;
    for (int i = 0; i < 8; i++) if (((m_disp >> (4*i)) & 32'hF) != 0) msd = i;
    if (blz && dig > msd) begin
      exp_anode = 8'hFF; exp_seg = 8'hFF;
    end else begin
      exp_anode = 8'hFF ^ 8'(1 << dig);
      exp_seg   = SEG_TBL[(m_disp >> (4*dig)) & 32'hF];
    end
    exp_frame = bnd;
    if (ld && bnd) begin m_disp = d; m_pv = 0; end
    else if (ld) begin m_pend = d; m_pv = 1; end
    else if (bnd && m_pv) begin m_disp = m_pend; m_pv = 0; end
    m_n++;
  endtask

  task automatic drive_cycle(input logic r, input logic ld, input logic [31:0] d, input logic blz);
    rst_n = r; load = ld; data = d; blank_lz = blz;
    model_step(r, ld, d, blz);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, (k == 1), 32'h87654321, 1'b0);
      n_chk++;
      if (anode !== 8'hFF || segment !== 8'hFF || frame !== 1'b0) begin
        n_err++;
        $display("FAIL reset k=%0d anode=%h seg=%h frame=%b want FF FF 0", k, anode, segment, frame);
      end
    end
  endtask

  task automatic test_scan_no_load;
    int first_frame = -1;
    int frames = 0;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      if (k <= 4) begin
        n_chk++;
        if (anode !== 8'hFE || segment !== 8'hC0) begin
          n_err++;
          $display("FAIL scan_digit0 k=%0d anode=%h seg=%h want FE C0", k, anode, segment);
        end
      end
      if (k == 5) begin
        n_chk++;
        if (anode !== 8'hFD) begin
          n_err++;
          $display("FAIL scan_digit1 anode=%h want FD", anode);
        end
      end
      if (frame === 1'b1) begin
        frames++;
        n_chk++;
        if (k != 32 * frames) begin
          n_err++;
          $display("FAIL frame_period pulse at k=%0d want k=%0d", k, 32 * frames);
        end
      end
    end
    n_chk++;
    if (frames != 2) begin
      n_err++;
      $display("FAIL frame_count got=%0d want 2", frames);
    end
  endtask

  task automatic test_load_mid;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 72; k++) begin
      drive_cycle(1'b1, (k == 5), 32'h12345678, 1'b0);
      n_chk++;
      if (anode !== exp_anode || segment !== exp_seg || frame !== exp_frame) begin
        n_err++;
        $display("FAIL load_mid k=%0d anode=%h/%h seg=%h/%h frame=%b/%b", k, anode, exp_anode, segment, exp_seg, frame, exp_frame);
      end
      if (k <= 32 && segment !== 8'hC0) begin
        n_err++;
        $display("FAIL no_tear k=%0d seg=%h want C0", k, segment);
      end
      if (k == 33 || k == 61) begin
        n_chk++;
        if ((k == 33 && (anode !== 8'hFE || segment !== 8'h80)) ||
            (k == 61 && (anode !== 8'h7F || segment !== 8'hF9))) begin
          n_err++;
          $display("FAIL load_mid_digit k=%0d anode=%h seg=%h", k, anode, segment);
        end
      end
    end
    n_chk++;
  endtask

  task automatic test_last_load_wins;
    logic ld;
    logic [31:0] d;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      ld = (k == 3) || (k == 10);
      d  = (k == 3) ? 32'hAAAAAAAA : 32'h0000BEEF;
      drive_cycle(1'b1, ld, d, 1'b0);
      n_chk++;
      if (anode !== exp_anode || segment !== exp_seg || frame !== exp_frame) begin
        n_err++;
        $display("FAIL last_load k=%0d anode=%h/%h seg=%h/%h frame=%b/%b", k, anode, exp_anode, segment, exp_seg, frame, exp_frame);
      end
      if (k == 45 || k == 49) begin
        n_chk++;
        if ((k == 45 && (anode !== 8'hF7 || segment !== 8'h83)) ||
            (k == 49 && (anode !== 8'hEF || segment !== 8'hC0))) begin
          n_err++;
          $display("FAIL last_load_digit k=%0d anode=%h seg=%h", k, anode, segment);
        end
      end
    end
  endtask

  task automatic test_boundary_load;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 96; k++) begin
      drive_cycle(1'b1, (k == 32), 32'hFFFFFFFF, 1'b0);
      n_chk++;
      if (anode !== exp_anode || segment !== exp_seg || frame !== exp_frame) begin
        n_err++;
        $display("FAIL bnd_load k=%0d anode=%h/%h seg=%h/%h frame=%b/%b", k, anode, exp_anode, segment, exp_seg, frame, exp_frame);
      end
      if (k >= 33) begin
        n_chk++;
        if (segment !== 8'h8E) begin
          n_err++;
          $display("FAIL bnd_load_seg k=%0d seg=%h want 8E", k, segment);
        end
      end
    end
  endtask

  task automatic test_blank;
    int dig;
    logic [7:0] ea, es;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      drive_cycle(1'b1, (k == 2), 32'h00000A05, 1'b1);
      dig = ((k - 1) % 32) / 4;
      if (k <= 32) begin
        ea = (dig == 0) ? 8'hFE : 8'hFF;
        es = (dig == 0) ? 8'hC0 : 8'hFF;
      end else begin
        case (dig)
          0: begin ea = 8'hFE; es = 8'h92; end
          1: begin ea = 8'hFD; es = 8'hC0; end
          2: begin ea = 8'hFB; es = 8'h88; end
          default: begin ea = 8'hFF; es = 8'hFF; end
        endcase
      end
      n_chk++;
      if (anode !== ea || segment !== es) begin
        n_err++;
        $display("FAIL blank k=%0d anode=%h/%h seg=%h/%h", k, anode, ea, segment, es);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 15; k++) drive_cycle(1'b1, (k == 10), 32'h12345678, 1'b0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    n_chk++;
    if (anode !== 8'hFF || segment !== 8'hFF || frame !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_hold anode=%h seg=%h frame=%b want FF FF 0", anode, segment, frame);
    end
    for (int k = 1; k <= 70; k++) begin
      drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      if (k == 1) begin
        n_chk++;
        if (anode !== 8'hFE || segment !== 8'hC0) begin
          n_err++;
          $display("FAIL rst_mid_release anode=%h seg=%h want FE C0", anode, segment);
        end
      end
      n_chk++;
      if (segment !== 8'hC0) begin
        n_err++;
        $display("FAIL rst_mid_disp k=%0d seg=%h want C0", k, segment);
      end
    end
  endtask

  task automatic test_random;
    logic r, ld, blz;
    logic [31:0] d;
    blz = 1'b0;
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 1200; k++) begin
      r   = ($urandom_range(0, 299) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      d   = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      drive_cycle(r, ld, d, blz);
      n_chk++;
      if (anode !== exp_anode || segment !== exp_seg || frame !== exp_frame) begin
        n_err++;
        $display("FAIL random k=%0d anode=%h/%h seg=%h/%h frame=%b/%b", k, anode, exp_anode, segment, exp_seg, frame, exp_frame);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data = 32'h0; blank_lz = 1'b0;
    m_n = 0; m_disp = 0; m_pend = 0; m_pv = 0;
    exp_anode = 8'hFF; exp_seg = 8'hFF; exp_frame = 1'b0;
    test_reset();
    test_scan_no_load();
    test_load_mid();
    test_last_load_wins();
    test_boundary_load();
    test_blank();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
